// File: rtl/bin_to_bcd_3d.sv
// ============================================================================
// Module   : bin_to_bcd_3d
// Brief    : Sequential 10-bit binary to 3-digit BCD converter (double dabble)
//            with registered digit outputs for a multiplexed 3-digit display.
//            A conversion takes 12 cycles, from start to the done pulse.
// Config   : BCD_OVERFLOW_SAT_EN - when defined, values above 999 show 9/9/9;
//            otherwise the digits show bin mod 1000. ovf is the same either way.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_3d (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [9:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] SEG0,
  output logic [3:0] SEG1,
  output logic [3:0] SEG2,
  output logic       ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] c_ITERATIONS = 4'd10;

  state_t      r_state;
  logic [9:0]  r_sr;       // binary shift register, MSB shifted out first
  logic [15:0] r_scr;      // BCD scratch: thousands/hundreds/tens/ones
  logic [3:0]  r_cnt;      // remaining SHIFT iterations
  logic        r_pend;     // a finished result waits to be published

  logic [15:0] w_adj;
  logic [15:0] w_scr_next;
  logic [9:0]  w_sr_next;
  logic        w_ovf;
  logic [11:0] w_digits;

  // Add-3 correction on every scratch nibble that is 5 or more
  always_comb begin
    w_adj = r_scr;
    for (int i = 0; i < 4; i++) begin
      if (r_scr[i*4 +: 4] >= 4'd5) begin
        w_adj[i*4 +: 4] = r_scr[i*4 +: 4] + 4'd3;
      end
    end
    w_scr_next = {w_adj[14:0], r_sr[9]};
    w_sr_next  = {r_sr[8:0], 1'b0};
  end

  // Final digit selection from the completed scratch register
  always_comb begin
    w_ovf = (r_scr[15:12] != 4'd0);
`ifdef BCD_OVERFLOW_SAT_EN
    w_digits = w_ovf ? 12'h999 : r_scr[11:0];
`else
    w_digits = r_scr[11:0];
`endif
  end

  // Control FSM, datapath and registered outputs
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      SEG0    <= '0;
      SEG1    <= '0;
      SEG2    <= '0;
      ovf     <= 1'b0;
    end else begin
      // busy lags the state by one cycle so it covers the 11 cycles between
      // capture and the done pulse, and is low while done is high
      busy <= (r_state == S_SHIFT) || (r_state == S_DONE);
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Publish the result finished in DONE; the scratch still holds it
          // even if a new start clears it at this same edge
          if (r_pend) begin
            SEG2   <= w_digits[11:8];
            SEG1   <= w_digits[7:4];
            SEG0   <= w_digits[3:0];
            ovf    <= w_ovf;
            done   <= 1'b1;
            r_pend <= 1'b0;
          end
          if (start) begin
            r_sr    <= bin;
            r_scr   <= '0;
            r_cnt   <= c_ITERATIONS;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_scr <= w_scr_next;
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_pend  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_3d.sv
// ============================================================================
// Module   : tb_bin_to_bcd_3d
// Brief    : Scoreboard bench for bin_to_bcd_3d. The driver pushes expected
//            digits when it issues an accepted start; a monitor pops and
//            compares on every done pulse and watches busy/hold/reset rules.
// Config   : BCD_OVERFLOW_SAT_EN selects the saturating reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_3d;

  logic       Clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [9:0] bin;
  logic       busy;
  logic       done;
  logic [3:0] SEG0, SEG1, SEG2;
  logic       ovf;

  typedef struct {
    int d2;
    int d1;
    int d0;
    int o;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic rst_s    = 1'b0;
  int   busy_cnt = 0;
  logic [12:0] last_out = '0;

  bin_to_bcd_3d dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .SEG0    (SEG0),
    .SEG1    (SEG1),
    .SEG2    (SEG2),
    .ovf     (ovf)
  );

  always #5 Clk = ~Clk;

  // Edge counter and sampled reset used by the monitor
  always @(posedge Clk) begin
    cyc   <= cyc + 1;
    rst_s <= reset_n;
  end

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: decimal digits from plain arithmetic
  function automatic exp_t model(input int v, input int c);
    exp_t e;
    int   m;
    e.o = (v > 999) ? 1 : 0;
`ifdef BCD_OVERFLOW_SAT_EN
    m = (v > 999) ? 999 : v;
`else
    m = v % 1000;
`endif
    e.d2  = m / 100;
    e.d1  = (m / 10) % 10;
    e.d0  = m % 10;
    e.cyc = c;
    return e;
  endfunction

  // Inputs change 1 time unit after the falling edge, clear of the monitor
  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  // One conversion; stray starts while busy must be ignored
  task automatic convert(input int v);
    bin   = 10'(v);
    start = 1'b1;
    q.push_back(model(v, cyc + 1));
    step();
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bin   = 10'($urandom);
      start = ($urandom_range(0, 3) == 0);
      step();
    end
    start = 1'b0;
  endtask

  // Monitor: scoreboard compare, busy length, hold and reset behaviour
  always @(negedge Clk) begin
    exp_t e;
    if (!rst_s) begin
      chk({busy, done, SEG2, SEG1, SEG0, ovf} == 15'd0, "reset_outputs",
          int'({busy, done, SEG2, SEG1, SEG0, ovf}), 0);
      last_out = '0;
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        chk(q.size() > 0, "unexpected_done", q.size(), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk(int'(SEG2) == e.d2, "SEG2", int'(SEG2), e.d2);
          chk(int'(SEG1) == e.d1, "SEG1", int'(SEG1), e.d1);
          chk(int'(SEG0) == e.d0, "SEG0", int'(SEG0), e.d0);
          chk(int'(ovf) == e.o, "ovf", int'(ovf), e.o);
          chk(cyc - e.cyc == 12, "latency", cyc - e.cyc, 12);
        end
        chk(SEG2 <= 4'd9 && SEG1 <= 4'd9 && SEG0 <= 4'd9, "digit_range",
            int'({SEG2, SEG1, SEG0}), 0);
        chk(busy == 1'b0, "busy_at_done", int'(busy), 0);
        chk(busy_cnt == 11, "busy_cycles", busy_cnt, 11);
        busy_cnt = 0;
        last_out = {SEG2, SEG1, SEG0, ovf};
      end else begin
        chk({SEG2, SEG1, SEG0, ovf} == last_out, "output_hold",
            int'({SEG2, SEG1, SEG0, ovf}), int'(last_out));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", q.size());
    $fatal(1);
  end

  initial begin
    int n0;
    int t;
    reset_n = 1'b0;
    start   = 1'b0;
    bin     = '0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Directed corner values
    convert(0);
    convert(999);
    convert(517);
    convert(1023);
    convert(1000);

    // start held high: captures only at the 12-cycle acceptance points
    step();
    bin   = 10'd123;
    start = 1'b1;
    n0    = cyc + 1;
    q.push_back(model(123, n0));
    step();
    while (cyc < n0 + 11) begin
      bin = 10'($urandom);
      step();
    end
    bin = 10'd456;
    q.push_back(model(456, cyc + 1));
    step();
    while (cyc < n0 + 23) begin
      bin = 10'($urandom);
      step();
    end
    start = 1'b0;
    repeat (3) step();

    // Reset at the 5th SHIFT cycle aborts; start during reset is ignored
    bin   = 10'd777;
    start = 1'b1;
    n0    = cyc + 1;
    step();
    start = 1'b0;
    while (cyc < n0 + 4) step();
    reset_n = 1'b0;
    start   = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    start   = 1'b0;
    repeat (15) step();
    chk({SEG2, SEG1, SEG0, ovf, busy} == 14'd0, "after_abort",
        int'({SEG2, SEG1, SEG0, ovf, busy}), 0);
    convert(42);

    // Exhaustive sweep, back to back
    for (int v = 0; v < 1024; v++) convert(v);

    t = 0;
    while (q.size() != 0 && t < 100) begin
      step();
      t++;
    end
    chk(q.size() == 0, "drain", q.size(), 0);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bin_to_bcd_3d.md
BIN_TO_BCD_3D -- requirements
Module: bin_to_bcd_3d

Interface
REQ-001 SHALL have port Clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, reset, synchronous and active-low, sampled on rising Clk.
REQ-003 SHALL have port start, input, 1, request to convert bin; sampled only while idle.
REQ-004 SHALL have port bin, input, 10, unsigned binary value to convert (0..1023).
REQ-005 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-006 SHALL have port done, output, 1, single-cycle pulse marking new digit values.
REQ-007 SHALL have port SEG0, output, 4, BCD ones digit, registered, for the 3-digit multiplexed display driver.
REQ-008 SHALL have port SEG1, output, 4, BCD tens digit, registered.
REQ-009 SHALL have port SEG2, output, 4, BCD hundreds digit, registered.
REQ-010 SHALL have port ovf, output, 1, registered; set when the last converted bin exceeded 999.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-012 IDLE: when start=1, SHALL capture bin into a 10-bit shift register, clear a 16-bit BCD scratch register, load a 4-bit iteration counter with 10, and enter SHIFT; when start=0, SHALL remain in IDLE.
REQ-013 SHIFT, each cycle: SHALL add 3 to every scratch nibble >=5, then shift {scratch, shift register} left by 1 and decrement the counter.
REQ-014 SHALL leave SHIFT for DONE after exactly 10 SHIFT cycles.
REQ-015 DONE, one cycle: SHALL update SEG0..SEG2 and ovf per REQ-027/028, pulse done in the following cycle, and return to IDLE.
REQ-016 Latency: start sampled at edge N -> done=1 and new SEG/ovf values visible in the cycle after edge N+12.
REQ-017 busy SHALL be 1 after edges N+1..N+11 and 0 in the cycle where done=1.
REQ-018 start while busy=1 SHALL be ignored, with no queuing; bin changes after capture SHALL NOT affect the result.
REQ-019 start=1 in the same cycle as done=1 SHALL be accepted (back-to-back throughput of 12 cycles).
REQ-020 SEG0..SEG2 and ovf SHALL hold their values between done pulses and never show intermediate scratch values.
REQ-021 Every output digit SHALL be in the range 0..9.
REQ-022 The scratch thousands nibble SHALL only ever hold 0 or 1; ovf = (thousands != 0) | (hundreds/tens/ones encode > 999 is impossible).

Reset
REQ-023 reset_n=0 at an edge SHALL force IDLE, busy=0, done=0, SEG0=SEG1=SEG2=0, ovf=0, and clear the counter and scratch.
REQ-024 Reset during SHIFT or DONE SHALL abort the conversion with no done pulse; the first start after release SHALL behave per REQ-016.
REQ-025 start asserted together with reset_n=0 SHALL be ignored.

Configuration
REQ-026 Macro BCD_OVERFLOW_SAT_EN SHALL select out-of-range handling; ovf behaves identically in both builds.
REQ-027 With BCD_OVERFLOW_SAT_EN defined: when bin > 999, SEG2/SEG1/SEG0 SHALL be 9/9/9.
REQ-028 Without BCD_OVERFLOW_SAT_EN: SEG2/SEG1/SEG0 SHALL be the digits of bin mod 1000, with the thousands nibble discarded.

Verification
REQ-029 Reset then bin=0, start pulse -> done 12 cycles after start edge, SEG=0/0/0, ovf=0, busy high exactly 11 cycles.
REQ-030 bin=999 -> SEG2/1/0=9/9/9, ovf=0; bin=10'd517 -> 5/1/7, ovf=0.
REQ-031 bin=1023 -> ovf=1; SAT build 9/9/9; non-SAT build 0/2/3; bin=1000 -> non-SAT build 0/0/0, ovf=1.
REQ-032 start held high continuously with bin=123 then bin=456 -> conversions every 12 cycles; bin changing mid-conversion does not alter the result; start during busy is ignored.
REQ-033 reset_n low at the 5th SHIFT cycle -> no done pulse, all outputs 0; a new start with bin=42 -> 0/4/2 after 12 cycles.
REQ-034 Exhaustive sweep of bin=0..1023 checked against a reference model: every digit 0..9, and exactly one done pulse per accepted start.
